// File: rtl/sum_output_stage_if.sv
// sum_output_stage_if: operand/carry upstream handshake and result downstream handshake.
// Macro SUM_STAGE_PARITY_EN adds the parity result signal.
interface sum_output_stage_if #(
    parameter int N_BIT = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [N_BIT-1:0] operand_1;
    logic [N_BIT-1:0] operand_2;
    logic             carry_in;
    logic [N_BIT-1:0] carry;
    logic             out_valid;
    logic             out_ready;
    logic [N_BIT-1:0] sum;
    logic             carry_out;
    logic             overflow;
`ifdef SUM_STAGE_PARITY_EN
    logic             parity;

    modport master (
        output in_valid, operand_1, operand_2, carry_in, carry, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, parity
    );
    modport slave (
        input  in_valid, operand_1, operand_2, carry_in, carry, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, parity
    );
`else
    modport master (
        output in_valid, operand_1, operand_2, carry_in, carry, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );
    modport slave (
        input  in_valid, operand_1, operand_2, carry_in, carry, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
`endif
endinterface

// File: rtl/sum_output_stage.sv
// sum_output_stage: sum/carry-out/overflow from a carry vector, held in a main+skid buffer.
// Optional macro SUM_STAGE_PARITY_EN adds an even-parity output that travels with each entry.
module sum_output_stage #(
    parameter int N_BIT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sum_output_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [N_BIT-1:0] sum;
        logic             cout;
        logic             ovf;
`ifdef SUM_STAGE_PARITY_EN
        logic             par;
`endif
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_new;
    logic [N_BIT-1:0] w_sum;
    logic             w_accept;
    logic             w_pop;
    logic             w_ld_main_new;
    logic             w_ld_main_skid;
    logic             w_ld_skid;

    // Carries arrive pre-computed; bit j sums with the carry out of bit j-1.
    assign w_sum = (bus.operand_1 ^ bus.operand_2)
                 ^ {bus.carry[N_BIT-2:0], bus.carry_in};

    always_comb begin
        w_new      = '0;
        w_new.sum  = w_sum;
        w_new.cout = bus.carry[N_BIT-1];
        w_new.ovf  = bus.carry[N_BIT-1] ^ bus.carry[N_BIT-2];
`ifdef SUM_STAGE_PARITY_EN
        w_new.par  = ^w_sum;
`endif
    end

    assign bus.in_ready  = (r_state != FULL);
    assign bus.out_valid = (r_state != EMPTY);
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_new  = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt   = ONE;
                    w_ld_main_new = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_ld_main_new = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = FULL;
                    w_ld_skid   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_state_nxt    = ONE;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_new) begin
                r_main <= w_new;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_new;
            end
        end
    end

    assign bus.sum       = r_main.sum;
    assign bus.carry_out = r_main.cout;
    assign bus.overflow  = r_main.ovf;
`ifdef SUM_STAGE_PARITY_EN
    assign bus.parity    = r_main.par;
`endif
endmodule
